// File: rtl/uart_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkt_ctrl
// Purpose  : Packet-level framing controller behind a UART byte receiver.
//            Parses HDR0 HDR1 CMD LEN PAYLOAD[LEN] CHK frames. Payload bytes
//            are written to a downstream FIFO, and each frame ends with a
//            one-cycle done or error pulse. An inter-byte timeout
//            resynchronises the parser after line stalls.
// Ports    : sys_clk, sys_rst_n         - clock, async active-low reset
//            uart_done, uart_data       - receiver byte-complete level + byte
//            fifo_full                  - downstream FIFO full
//            fifo_wr_en, fifo_wr_data   - payload write strobe + byte
//            pkt_cmd, pkt_len           - command/length of current/last frame
//            pkt_done, pkt_err          - frame ok / frame aborted pulses
//            err_code                   - 0 chksum, 1 timeout, 2 len, 3 ovf
//            busy                       - parser not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_pkt_ctrl #(
  parameter int          CLK_FREQ      = 50000000,
  parameter int          UART_BPS      = 9600,
  parameter int          TIMEOUT_BYTES = 4,
  parameter int          MAX_LEN       = 64,
  parameter logic [7:0]  HDR0          = 8'h55,
  parameter logic [7:0]  HDR1          = 8'hAA
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_done,
  input  logic [7:0] uart_data,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_wr_data,
  output logic [7:0] pkt_cmd,
  output logic [7:0] pkt_len,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int          TIMEOUT_CYC = CLK_FREQ / UART_BPS * 10 * TIMEOUT_BYTES;
  localparam logic [23:0] TMO_LAST    = 24'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);

  localparam logic [1:0]  ERR_CHKSUM  = 2'd0;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd1;
  localparam logic [1:0]  ERR_LENGTH  = 2'd2;
  localparam logic [1:0]  ERR_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_CMD  = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_CHK  = 3'd5
  } state_t;

  state_t      state_q,   state_d;
  logic        done_d0_q;
  logic [7:0]  cnt_q,     cnt_d;
  logic [7:0]  csum_q,    csum_d;
  logic        ovf_q,     ovf_d;
  logic [23:0] tmo_q,     tmo_d;
  logic [7:0]  cmd_q,     cmd_d;
  logic [7:0]  len_q,     len_d;
  logic        wr_en_q,   wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        done_q,    done_d;
  logic        err_q,     err_d;
  logic [1:0]  code_q,    code_d;
  logic        busy_q,    busy_d;

  // uart_done is a level held for several cycles; its rising edge marks
  // exactly one new byte.
  logic byte_vld;
  assign byte_vld = uart_done & ~done_d0_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;

    if (byte_vld) begin
      // A byte arriving in the expiry cycle wins over the timeout.
      tmo_d = 24'd0;
      case (state_q)
        S_IDLE: begin
          if (uart_data == HDR0) state_d = S_HDR;
        end
        S_HDR: begin
          if (uart_data == HDR1) begin
            state_d = S_CMD;
            csum_d  = 8'd0;
            ovf_d   = 1'b0;
          end else if (uart_data != HDR0) begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          cmd_d   = uart_data;
          csum_d  = csum_q + uart_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          len_d  = uart_data;
          csum_d = csum_q + uart_data;
          if (uart_data == 8'd0) begin
            state_d = S_CHK;
          end else if (uart_data > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = ERR_LENGTH;
            state_d = S_IDLE;
          end else begin
            cnt_d   = uart_data;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          csum_d = csum_q + uart_data;
          cnt_d  = cnt_q - 8'd1;
          if (fifo_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = uart_data;
          end
          if (cnt_q == 8'd1) state_d = S_CHK;
        end
        S_CHK: begin
          // Overflow is reported even when the checksum matches.
          if (ovf_q) begin
            err_d  = 1'b1;
            code_d = ERR_OVERFLOW;
          end else if (uart_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHKSUM;
          end
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d   = 24'd0;
        state_d = S_IDLE;
        // A stall after a lone header byte is just line noise: drop silently.
        if (state_q != S_HDR) begin
          err_d  = 1'b1;
          code_d = ERR_TIMEOUT;
        end
      end else begin
        tmo_d = tmo_q + 24'd1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      done_d0_q <= 1'b0;
      cnt_q     <= 8'd0;
      csum_q    <= 8'd0;
      ovf_q     <= 1'b0;
      tmo_q     <= 24'd0;
      cmd_q     <= 8'd0;
      len_q     <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_d0_q <= uart_done;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign pkt_cmd      = cmd_q;
  assign pkt_len      = len_q;
  assign pkt_done     = done_q;
  assign pkt_err      = err_q;
  assign err_code     = code_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_pkt_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_pkt_ctrl
// Purpose  : Self-checking bench for uart_pkt_ctrl: vector table, directed
//            timeout/reset sequences and randomized frames compared against
//            expectations built while the frames are generated.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_pkt_ctrl;

  localparam int CLK_FREQ      = 1000000;
  localparam int UART_BPS      = 100000;
  localparam int TIMEOUT_BYTES = 4;
  localparam int MAX_LEN       = 64;
  localparam int TIMEOUT_CYC   = CLK_FREQ / UART_BPS * 10 * TIMEOUT_BYTES;
  localparam logic [7:0] HDR0  = 8'h55;
  localparam logic [7:0] HDR1  = 8'hAA;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_done = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic       fifo_full = 1'b0;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic [7:0] pkt_cmd;
  logic [7:0] pkt_len;
  logic       pkt_done;
  logic       pkt_err;
  logic [1:0] err_code;
  logic       busy;

  uart_pkt_ctrl #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .TIMEOUT_BYTES(TIMEOUT_BYTES),
    .MAX_LEN(MAX_LEN), .HDR0(HDR0), .HDR1(HDR1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_done(uart_done),
    .uart_data(uart_data), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .pkt_cmd(pkt_cmd), .pkt_len(pkt_len),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int last_strobe = 0;

  // Event record: {kind[2:0], cmd, len}; kind 4 = done, 0..3 = err code.
  logic [7:0]  got_wr[$];
  logic [18:0] got_ev[$];
  int          ev_cyc[$];
  logic [7:0]  exp_wr[$];
  logic [18:0] exp_ev[$];

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (fifo_wr_en) got_wr.push_back(fifo_wr_data);
      if (pkt_done && pkt_err) overlap++;
      if (pkt_done) begin
        got_ev.push_back({3'd4, pkt_cmd, pkt_len});
        ev_cyc.push_back(cyc);
      end else if (pkt_err) begin
        got_ev.push_back({1'b0, err_code, pkt_cmd, pkt_len});
        ev_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_wr.delete();
    got_ev.delete();
    ev_cyc.delete();
  endtask

  // Present one byte: uart_done held high three cycles; fifo_full is held
  // across the same window so it is seen in the strobe cycle.
  task automatic send_byte(input logic [7:0] b, input logic full, input int gap);
    repeat (gap) @(posedge sys_clk);
    @(posedge sys_clk); #1;
    uart_data   = b;
    fifo_full   = full;
    uart_done   = 1'b1;
    last_strobe = cyc;
    repeat (3) @(posedge sys_clk);
    #1;
    uart_done = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic wait_ev(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(negedge sys_clk); #1;
      if (got_ev.size() > 0) seen = 1'b1;
    end
  endtask

  typedef struct packed {
    logic [3:0]  n;     // bytes sent
    logic [79:0] b;     // byte i at b[79-8*i -: 8]
    logic [9:0]  full;  // fifo_full during byte i
    logic [2:0]  nwr;   // expected fifo writes
    logic [31:0] wr;    // write i at wr[31-8*i -: 8]
    logic [2:0]  ev;    // 4 = done, 0..3 = err code
    logic [7:0]  cmd;
    logic [7:0]  len;
  } vec_t;

  localparam int NV = 6;
  vec_t vec [NV];

  bit          seen;
  int          lat;
  int          typ, nj, ln;
  logic [7:0]  cmd, d, sum, jb;
  logic        full, any_full;
  logic [2:0]  kind;

  initial begin
    vec[0] = '{4'd8, {8'h55,8'hAA,8'h01,8'h03,8'h11,8'h22,8'h33,8'h6A,16'h0}, 10'h000,
               3'd3, {8'h11,8'h22,8'h33,8'h00}, 3'd4, 8'h01, 8'h03};
    vec[1] = '{4'd8, {8'h55,8'hAA,8'h01,8'h03,8'h11,8'h22,8'h33,8'h6B,16'h0}, 10'h000,
               3'd3, {8'h11,8'h22,8'h33,8'h00}, 3'd0, 8'h01, 8'h03};
    vec[2] = '{4'd6, {8'h55,8'h55,8'hAA,8'h02,8'h00,8'h02,32'h0}, 10'h000,
               3'd0, 32'h0, 3'd4, 8'h02, 8'h00};
    vec[3] = '{4'd4, {8'h55,8'hAA,8'h01,8'h41,48'h0}, 10'h000,
               3'd0, 32'h0, 3'd2, 8'h01, 8'h41};
    vec[4] = vec[0];
    vec[5] = '{4'd8, {8'h55,8'hAA,8'h01,8'h03,8'h11,8'h22,8'h33,8'h6A,16'h0}, 10'h020,
               3'd2, {8'h11,8'h33,16'h0}, 3'd3, 8'h01, 8'h03};

    // Reset state
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_outputs", int'({fifo_wr_en, fifo_wr_data, pkt_cmd, pkt_len,
                               pkt_done, pkt_err, err_code, busy}), 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);

    // Table-driven frames
    for (int v = 0; v < NV; v++) begin
      clear_mon();
      for (int i = 0; i < int'(vec[v].n); i++)
        send_byte(vec[v].b[79-8*i -: 8], vec[v].full[i], 1);
      repeat (6) @(posedge sys_clk);
      #1;
      check($sformatf("v%0d_nwr", v), got_wr.size(), int'(vec[v].nwr));
      for (int i = 0; i < int'(vec[v].nwr) && i < got_wr.size(); i++)
        check($sformatf("v%0d_wr%0d", v, i), int'(got_wr[i]), int'(vec[v].wr[31-8*i -: 8]));
      check($sformatf("v%0d_nev", v), got_ev.size(), 1);
      if (got_ev.size() > 0) begin
        check($sformatf("v%0d_kind", v), int'(got_ev[0][18:16]), int'(vec[v].ev));
        check($sformatf("v%0d_cmd", v), int'(got_ev[0][15:8]), int'(vec[v].cmd));
        check($sformatf("v%0d_len", v), int'(got_ev[0][7:0]), int'(vec[v].len));
        check($sformatf("v%0d_lat", v), ev_cyc[0] - last_strobe, 1);
      end
      check($sformatf("v%0d_busy", v), int'(busy), 0);
    end

    // Timeout mid-frame
    clear_mon();
    send_byte(HDR0, 1'b0, 1);
    send_byte(HDR1, 1'b0, 1);
    send_byte(8'h01, 1'b0, 1);
    check("tmo_busy_hi", int'(busy), 1);
    wait_ev(TIMEOUT_CYC + 20, seen);
    check("tmo_seen", int'(seen), 1);
    if (seen) begin
      check("tmo_code", int'(got_ev[0][18:16]), 1);
      // Counter starts from zero the cycle after the strobe; the registered
      // error therefore lands TIMEOUT_CYC..TIMEOUT_CYC+1 cycles after it.
      lat = ev_cyc[0] - last_strobe;
      check("tmo_lat", int'(lat >= TIMEOUT_CYC && lat <= TIMEOUT_CYC + 1), 1);
    end
    repeat (2) @(posedge sys_clk);
    #1;
    check("tmo_busy_lo", int'(busy), 0);

    // Timeout after a lone header byte is silent
    clear_mon();
    send_byte(HDR0, 1'b0, 1);
    wait_ev(TIMEOUT_CYC + 20, seen);
    check("hdr_tmo_silent", int'(seen), 0);
    check("hdr_tmo_busy", int'(busy), 0);

    // Byte arriving in the expiry cycle wins over the timeout
    clear_mon();
    send_byte(HDR0, 1'b0, 1);
    send_byte(HDR1, 1'b0, 1);
    send_byte(8'h01, 1'b0, 1);
    send_byte(8'h03, 1'b0, 1);
    send_byte(8'h11, 1'b0, TIMEOUT_CYC - 4);
    send_byte(8'h22, 1'b0, 1);
    send_byte(8'h33, 1'b0, 1);
    send_byte(8'h6A, 1'b0, 1);
    repeat (6) @(posedge sys_clk);
    check("race_nev", got_ev.size(), 1);
    if (got_ev.size() > 0) check("race_kind", int'(got_ev[0][18:16]), 4);
    check("race_nwr", got_wr.size(), 3);

    // Reset mid-frame: no pulse, parser idle, next frame accepted
    clear_mon();
    send_byte(HDR0, 1'b0, 1);
    send_byte(HDR1, 1'b0, 1);
    send_byte(8'h01, 1'b0, 1);
    send_byte(8'h03, 1'b0, 1);
    send_byte(8'h11, 1'b0, 1);
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_cmd", int'(pkt_cmd), 0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(vec[0].b[79-8*i -: 8], 1'b0, 1);
    repeat (6) @(posedge sys_clk);
    check("mrst_nwr", got_wr.size(), 4);
    check("mrst_nev", got_ev.size(), 1);
    if (got_ev.size() > 0) check("mrst_kind", int'(got_ev[0][18:16]), 4);

    // Randomized frames
    clear_mon();
    exp_wr.delete();
    exp_ev.delete();
    for (int f = 0; f < 30; f++) begin
      typ = $urandom_range(0, 3);
      nj  = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        jb = 8'($urandom);
        if (jb == HDR0) jb = 8'h00;
        send_byte(jb, 1'b0, $urandom_range(0, 4));
      end
      cmd = 8'($urandom);
      if (typ == 2)      ln = $urandom_range(MAX_LEN + 1, 255);
      else if (f % 5 == 0) ln = MAX_LEN;
      else               ln = $urandom_range(0, MAX_LEN);
      send_byte(HDR0, 1'b0, $urandom_range(0, 4));
      send_byte(HDR1, 1'b0, $urandom_range(0, 4));
      send_byte(cmd, 1'b0, $urandom_range(0, 4));
      send_byte(8'(ln), 1'b0, $urandom_range(0, 4));
      if (typ == 2) begin
        exp_ev.push_back({3'd2, cmd, 8'(ln)});
      end else begin
        sum = cmd + 8'(ln);
        any_full = 1'b0;
        for (int i = 0; i < ln; i++) begin
          d    = 8'($urandom);
          full = (typ == 3) && ($urandom_range(0, 3) == 0);
          sum  = sum + d;
          if (full) any_full = 1'b1;
          else      exp_wr.push_back(d);
          send_byte(d, full, $urandom_range(0, 4));
        end
        send_byte((typ == 1) ? sum + 8'd1 : sum, 1'b0, $urandom_range(0, 4));
        if (any_full)      kind = 3'd3;
        else if (typ == 1) kind = 3'd0;
        else               kind = 3'd4;
        exp_ev.push_back({kind, cmd, 8'(ln)});
      end
    end
    repeat (10) @(posedge sys_clk);
    check("rnd_nwr", got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      if (got_wr[i] != exp_wr[i]) check($sformatf("rnd_wr%0d", i), int'(got_wr[i]), int'(exp_wr[i]));
    check("rnd_nev", got_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
      check($sformatf("rnd_ev%0d", i), int'(got_ev[i]), int'(exp_ev[i]));

    check("done_err_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
